// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time programmable serial pattern detection controller.
// A pattern of up to MAX_LEN bits is loaded through a cfg handshake. Each run
// counts matches over a valid/ready bit stream. A run ends on the target count,
// on abort or, in the optional build, on the watchdog.
// Optional feature macro: SEQ_DET_CTRL_TIMEOUT_EN. When it is defined, a watchdog
// ends a run after TIMEOUT_CYC accepted bits arrive without a match.
module seq_detect_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic [CNT_W-1:0]               cfg_target,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           bit_valid,
  input  logic                           bit_data,
  output logic                           bit_ready,
  output logic                           match,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [CNT_W-1:0]   tgt_r;

  logic [MAX_LEN-1:0] history_r;
  logic [LEN_W-1:0]   fill_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               match_r;
  logic               done_r;

  logic               accept_s;
  logic               run_entry_s;
  logic [MAX_LEN-1:0] hist_nxt_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               match_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               tgt_hit_s;
  logic               to_hit_s;

  // Per-bit datapath. Abort overrides acceptance. The match test includes the incoming bit.
  always_comb begin
    accept_s    = (state_r == ST_RUN) && bit_valid && !abort;
    run_entry_s = (state_r == ST_ARMED) && start && !abort;
    hist_nxt_s  = {history_r[MAX_LEN-2:0], bit_data};
    if (fill_r >= MAX_LEN_L) begin
      fill_inc_s = MAX_LEN_L;
    end else begin
      fill_inc_s = fill_r + LEN_W'(1);
    end
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
    match_s = accept_s && (fill_inc_s >= len_r) &&
              (((hist_nxt_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
    if (&cnt_r) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
    tgt_hit_s = match_s && (tgt_r != {CNT_W{1'b0}}) && (cnt_inc_s == tgt_r);
  end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_r;
  logic            timeout_r;
  logic [WD_W-1:0] wd_inc_s;

  // Watchdog trip detection. A match on the same bit takes priority.
  always_comb begin
    wd_inc_s = wd_r + WD_W'(1);
    to_hit_s = accept_s && !match_s && (wd_inc_s == WD_W'(TIMEOUT_CYC));
  end

  // The watchdog counts accepted bits since run entry or the last match. Timeout is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r      <= {WD_W{1'b0}};
      timeout_r <= 1'b0;
    end else if (run_entry_s) begin
      wd_r      <= {WD_W{1'b0}};
      timeout_r <= 1'b0;
    end else if (accept_s) begin
      if (match_s || to_hit_s) begin
        wd_r <= {WD_W{1'b0}};
      end else begin
        wd_r <= wd_inc_s;
      end
      if (to_hit_s) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end else begin
      wd_r      <= wd_r;
      timeout_r <= timeout_r;
    end
  end

  assign timeout = timeout_r;
`else
  assign to_hit_s = 1'b0;
  assign timeout  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Abort has precedence over every other event.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (cfg_valid) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (tgt_hit_s || to_hit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from the registered state.
  always_comb begin
    cfg_ready = 1'b0;
    bit_ready = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE:  cfg_ready = 1'b1;
      ST_ARMED: cfg_ready = 1'b0;
      ST_RUN: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE:  busy = 1'b0;
      default: begin
        cfg_ready = 1'b0;
        bit_ready = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Configuration latch. Out-of-range lengths are clamped to MAX_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r <= {MAX_LEN{1'b0}};
      len_r <= MAX_LEN_L;
      ovl_r <= 1'b0;
      tgt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_IDLE) && cfg_valid && !abort) begin
      pat_r <= cfg_pattern;
      if ((cfg_len == {LEN_W{1'b0}}) || (cfg_len > MAX_LEN_L)) begin
        len_r <= MAX_LEN_L;
      end else begin
        len_r <= cfg_len;
      end
      ovl_r <= cfg_overlap;
      tgt_r <= cfg_target;
    end else begin
      pat_r <= pat_r;
      len_r <= len_r;
      ovl_r <= ovl_r;
      tgt_r <= tgt_r;
    end
  end

  // Shift history and fill. In non-overlap mode a match empties the fill so used bits are not reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_r <= {MAX_LEN{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
    end else if (run_entry_s) begin
      history_r <= {MAX_LEN{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      history_r <= hist_nxt_s;
      if (match_s && !ovl_r) begin
        fill_r <= {LEN_W{1'b0}};
      end else begin
        fill_r <= fill_inc_s;
      end
    end else begin
      history_r <= history_r;
      fill_r    <= fill_r;
    end
  end

  // Registered match pulse, saturating match counter and end-of-run done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_r <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      match_r <= match_s;
      done_r  <= (state_r == ST_RUN) && (state_nxt_s != ST_RUN);
      if (run_entry_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (match_s) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign match     = match_r;
  assign done      = done_r;
  assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl. It uses randomized stimulus and a queue-based reference model.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               bit_valid = 1'b0;
  logic               bit_data = 1'b0;
  logic               bit_ready;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               timeout;

  int checks = 0;
  int errors = 0;

  // reference model: the accepted bits that can still contribute to a match
  int               m_len;
  logic [7:0]       m_pat;
  bit               m_ovl;
  int               m_tgt;
  bit               m_q[$];
  int               m_cnt;
  bit               m_run;
  bit               stim[$];
  int               pos_q[$];

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic bit model_push(input bit b);
    bit hit;
    m_q.push_back(b);
    if (m_q.size() > 2 * MAX_LEN) void'(m_q.pop_front());
    hit = 1'b0;
    if (m_q.size() >= m_len) begin
      hit = 1'b1;
      for (int k = 0; k < m_len; k++)
        if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
    end
    if (hit) begin
      if (m_cnt < 255) m_cnt++;
      if (!m_ovl) m_q.delete();
      if (m_tgt != 0 && m_cnt == m_tgt) m_run = 1'b0;
    end
    return hit;
  endfunction

  task automatic go_idle();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    m_run = 1'b0;
  endtask

  task automatic configure(input logic [7:0] pat, input int len, input bit ovl, input int tgt);
    cfg_pattern = pat; cfg_len = len[3:0]; cfg_overlap = ovl; cfg_target = tgt[7:0];
    cfg_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0; start = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL cfg_armed: cfg_ready=%b busy=%b expected 0 0", cfg_ready, busy);
    if (cfg_ready !== 1'b0 || busy !== 1'b0) errors++;
    m_len = (len == 0 || len > MAX_LEN) ? MAX_LEN : len;
    m_pat = pat; m_ovl = ovl; m_tgt = tgt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_q.delete(); m_cnt = 0; m_run = 1'b1;
    checks++;
    if (busy !== 1'b1 || match_cnt !== 8'd0 || bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: busy=%b cnt=%0d ready=%b expected 1 0 1", busy, match_cnt, bit_ready);
    end
  endtask

  task automatic load_stim(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    stim.delete();
    for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
  endtask

  task automatic run_stream(input int gap_pct);
    int idx, acc_n, budget;
    bit acc, expm, expd;
    idx = 0; acc_n = 0; budget = stim.size() * 8 + 20;
    pos_q.delete();
    for (int c = 0; c < budget && m_run && idx < stim.size(); c++) begin
      bit_valid = ($urandom_range(99) >= gap_pct);
      bit_data  = stim[idx];
      @(posedge clk);
      acc = bit_valid && m_run; expm = 1'b0; expd = 1'b0;
      if (acc) begin
        acc_n++;
        expm = model_push(stim[idx]);
        expd = !m_run;
        idx++;
      end
      #1;
      if (match === 1'b1) pos_q.push_back(acc_n);
      checks++;
      if (match !== expm || done !== expd) begin
        errors++;
        $display("FAIL stream_pulse: bit %0d match=%b done=%b expected %b %b", acc_n, match, done, expm, expd);
      end
      checks++;
      if (match_cnt !== m_cnt[7:0] || bit_ready !== m_run) begin
        errors++;
        $display("FAIL stream_state: bit %0d cnt=%0d ready=%b expected %0d %b", acc_n, match_cnt, bit_ready, m_cnt, m_run);
      end
    end
    bit_valid = 1'b0;
    checks++;
    if (m_run && idx < stim.size()) begin
      errors++;
      $display("FAIL stream_budget: consumed %0d bits expected %0d", idx, stim.size());
    end
  endtask

  task automatic check_positions(input string name, input int n, input int p0, input int p1);
    checks++;
    if (pos_q.size() != n || (n > 0 && pos_q[0] != p0) || (n > 1 && pos_q[1] != p1)) begin
      errors++;
      $display("FAIL %s: %0d matches first at %0d expected %0d at %0d,%0d", name, pos_q.size(),
               (pos_q.size() > 0) ? pos_q[0] : -1, n, p0, p1);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (match !== 1'b0 || match_cnt !== 8'd0 || done !== 1'b0 || busy !== 1'b0 ||
        timeout !== 1'b0 || bit_ready !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: m=%b c=%0d d=%b b=%b t=%b r=%b cr=%b expected 0 0 0 0 0 0 1",
               match, match_cnt, done, busy, timeout, bit_ready, cfg_ready);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_overlap();
    go_idle();
    configure(8'b10010, 5, 1'b1, 0);
    load_stim(16'b1001001001, 10);
    run_stream(0);
    check_positions("overlap_pos", 2, 5, 8);
    checks++;
    if (match_cnt !== 8'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overlap_cnt: cnt=%0d busy=%b expected 2 1", match_cnt, busy);
    end
  endtask

  task automatic test_nonoverlap();
    go_idle();
    configure(8'b10010, 5, 1'b0, 0);
    load_stim(16'b1001001001, 10);
    run_stream(0);
    check_positions("nonoverlap_pos", 1, 5, 0);
    checks++;
    if (match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL nonoverlap_cnt: cnt=%0d expected 1", match_cnt);
    end
  endtask

  task automatic test_target();
    go_idle();
    configure(8'b10010, 5, 1'b1, 2);
    load_stim(16'b1001001011111111, 16);
    run_stream(0);
    check_positions("target_pos", 2, 5, 8);
    bit_valid = 1'b1; bit_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bit_ready !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0 ||
          match !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd2) begin
        errors++;
        $display("FAIL target_armed: ready=%b busy=%b cfg_ready=%b match=%b done=%b cnt=%0d expected 0 0 0 0 0 2",
                 bit_ready, busy, cfg_ready, match, done, match_cnt);
      end
    end
    bit_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL target_rerun: busy=%b cnt=%0d expected 1 0", busy, match_cnt);
    end
  endtask

  task automatic test_abort();
    go_idle();
    configure(8'b10010, 5, 1'b1, 0);
    load_stim(16'b100, 3);
    run_stream(0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_run: done=%b cfg_ready=%b busy=%b expected 1 1 0", done, cfg_ready, busy);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_start_ignored: done=%b busy=%b cfg_ready=%b expected 0 0 1", done, busy, cfg_ready);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: done=%b cfg_ready=%b expected 0 1", done, cfg_ready);
    end
  endtask

  task automatic test_gaps();
    go_idle();
    configure(8'b10010, 5, 1'b1, 0);
    load_stim(16'b1001001001, 10);
    run_stream(50);
    check_positions("gap_pos", 2, 5, 8);
  endtask

  task automatic test_random();
    int len, tgt, n;
    for (int it = 0; it < 20; it++) begin
      go_idle();
      len = $urandom_range(15);
      tgt = $urandom_range(3);
      configure(8'($urandom), len, 1'($urandom), tgt);
      n = 30;
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(1'($urandom));
      run_stream(30);
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    configure(8'b10010, 5, 1'b1, 0);
    load_stim(16'b1001001, 7);
    run_stream(0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (match !== 1'b0 || match_cnt !== 8'd0 || done !== 1'b0 || busy !== 1'b0 ||
        timeout !== 1'b0 || bit_ready !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: m=%b c=%0d d=%b b=%b t=%b r=%b cr=%b expected 0 0 0 0 0 0 1",
               match, match_cnt, done, busy, timeout, bit_ready, cfg_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_done: done=%b cfg_ready=%b expected 0 1", done, cfg_ready);
    end
    m_run = 1'b0;
  endtask

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    go_idle();
    configure(8'b11, 2, 1'b1, 0);
    bit_valid = 1'b1; bit_data = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      checks++;
      if (timeout !== (i == 64) || done !== (i == 64)) begin
        errors++;
        $display("FAIL timeout_bit: bit %0d timeout=%b done=%b expected %b", i, timeout, done, (i == 64));
      end
    end
    bit_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_target();
    test_abort();
    test_gaps();
    test_random();
    test_async_reset();
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-time programmable serial pattern detection controller.
- Accepts a pattern of up to MAX_LEN bits, its length, an overlap mode and a target match count through a configuration handshake.
- Sequences a detection run over a valid/ready serial bit stream, counts matches, and terminates the run on target count or abort.
- Sits between the register/command interface and the serial data source. It replaces the fixed-pattern detectors with one configurable engine.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target
TIMEOUT_CYC, 64, accepted-bit limit without a match before timeout (used only with SEQ_DET_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration present
cfg_ready  out  1  controller accepts configuration (high only in IDLE)
cfg_pattern  in  MAX_LEN  pattern; cfg_pattern[len-1] is the first bit in time
cfg_len  in  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  in  CNT_W  number of matches ending the run; 0 = unlimited
start  in  1  begin run (honoured in ARMED only)
abort  in  1  terminate run immediately
bit_valid  in  1  serial bit present
bit_data  in  1  serial bit
bit_ready  out  1  controller accepts bit (high only in RUN)
match  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  matches in the current run
busy  out  1  state is RUN
done  out  1  one-cycle pulse when the run ends
timeout  out  1  sticky, set by watchdog (feature only; otherwise tied 0)

Behaviour:
- Reset: state = IDLE. Output values: match = 0, match_cnt = 0, done = 0, busy = 0, timeout = 0, bit_ready = 0, cfg_ready = 1. History and fill counter are cleared.
- The async reset may assert at any point mid-run. The run is lost; no done pulse is generated.
- States:
  - IDLE: cfg_ready = 1. On cfg_valid, latch pattern/len/overlap/target and go to ARMED. cfg_len of 0 or greater than MAX_LEN is clamped to MAX_LEN.
  - ARMED: start goes to RUN. On entry to RUN, clear match_cnt, history, fill and timeout. A new cfg_valid in ARMED is ignored (cfg_ready = 0).
  - RUN: bit_ready = 1. A bit is accepted when bit_valid & bit_ready.
    - history <= {history[MAX_LEN-2:0], bit_data}.
    - fill <= min(fill+1, MAX_LEN).
  - DONE: done = 1 for exactly one cycle, then ARMED. The same config can be re-run with start; cfg is reloadable only via abort → IDLE.
- Match condition, evaluated on the accepted bit including it: fill_after ≥ len and history_after[len-1:0] == pattern[len-1:0].
- On a match:
  - match pulses 1 cycle after the final bit is accepted (registered).
  - match_cnt increments, saturating at all-ones.
  - If overlap = 0, fill is set to 0 so that bits already used cannot contribute to the next match. If overlap = 1, fill is kept.
- Termination: if target ≠ 0 and the incremented count equals target, the next state is DONE. match and done pulse in the same cycle. bit_ready drops in that cycle, so no bit beyond the target-completing bit is consumed.
- abort: any state → IDLE next cycle, with precedence over start, cfg_valid and bit acceptance.
  - From RUN, done pulses once.
  - From IDLE or ARMED, no done pulse.
  - match_cnt holds its value until the next RUN entry.
- start outside ARMED is ignored. A start in the same cycle as cfg_valid in IDLE is ignored.
- bit_valid without bit_ready causes no state change. A stall (bit_valid = 0) keeps history and fill.

Optional Feature:
Macro SEQ_DET_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter counts accepted bits since RUN entry or the last match.
  - When it reaches TIMEOUT_CYC, timeout is set (sticky until next RUN entry) and the state goes to DONE with a done pulse.
  - If a match occurs on the same bit, the match wins and the counter is cleared.
- Undefined: no counter is present, timeout is constant 0, and a run ends only on target or abort.

Test Plan:
- Configure pattern=5'b10010, len=5, overlap=1, target=0; start; stream 1001001001 continuously → match after bits 5 and 8, match_cnt=2, no done.
- Same stream, overlap=0 → single match after bit 5, match_cnt=1.
- Set target=2, overlap=1, stream 10010010 then more 1s → done and match pulse together after bit 8, bit_ready low from the next cycle, state ARMED, match_cnt=2.
- Mid-run abort after 3 bits → done pulse once, IDLE next cycle, cfg_ready=1; a subsequent start without cfg is ignored.
- Random bit_valid gaps (50%) on the first scenario → identical match count and positions relative to accepted bits. Also assert rst_n low mid-run → all outputs at reset values asynchronously.
- With SEQ_DET_CTRL_TIMEOUT_EN and TIMEOUT_CYC=64, stream 64 zeros → timeout=1 and a done pulse after bit 64.
